// File: rtl/pacman_tile_pkg.sv
// pacman_tile_pkg: tile map geometry, code/address types and clear-engine states
package pacman_tile_pkg;
    localparam int H_TILES = 80;
    localparam int V_TILES = 60;
    localparam int CODE_W = 4;
    localparam int N_TILES = H_TILES * V_TILES;
    localparam logic [CODE_W-1:0] CLEAR_CODE = 4'h8;
    typedef logic [CODE_W-1:0] sprite_code_t;
    typedef logic [12:0] tile_addr_t;
    typedef enum logic {IDLE, CLEAR} clr_state_e;
    // ty*80 as ty*64 + ty*16
    function automatic tile_addr_t tile_addr(input logic [6:0] tx, input logic [6:0] ty);
        return tile_addr_t'({ty, 6'b0}) + tile_addr_t'({ty, 4'b0}) + tile_addr_t'(tx);
    endfunction
endpackage

// File: rtl/tile_ram_dp.sv
// tile_ram_dp: dual-port read-first tile map, port A read-only, port B read/write
module tile_ram_dp
    import pacman_tile_pkg::*;
(
    input  logic         clk,
    input  tile_addr_t   addr_a,
    output sprite_code_t q_a,
    input  tile_addr_t   addr_b,
    input  logic         we_b,
    input  sprite_code_t d_b,
    output sprite_code_t q_b
);
    sprite_code_t mem [N_TILES];
    always_ff @(posedge clk) begin
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
        if (we_b) mem[addr_b] <= d_b;
    end
endmodule

// File: rtl/tile_fetcher.sv
// tile_fetcher: walks the tile map from VGA coordinates, serves a game port and clears the map
module tile_fetcher
    import pacman_tile_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [9:0]   px,
    input  logic [9:0]   py,
    input  logic         de_in,
    output logic [2:0]   sx,
    output logic [2:0]   sy,
    output sprite_code_t sprite_code,
    output logic         de_out,
    input  logic [6:0]   gx,
    input  logic [5:0]   gy,
    input  logic         wr_en,
    input  sprite_code_t wr_code,
    input  logic         rd_en,
    output sprite_code_t rd_code,
    output logic         rd_valid,
    input  logic         clr_start,
    output logic         clr_busy
);
    logic [6:0] tx, ty;
    logic in_map, g_in, we_b, last;
    logic [2:0] sx1, sy1;
    logic de1, in1, rd_oor;
    tile_addr_t addr_a, addr_b, clr_cnt, clr_cnt_n;
    sprite_code_t q_a, q_b, d_b;
    clr_state_e state, state_n;

    assign tx = px[9:3];
    assign ty = py[9:3];

    // off-map coordinates park the RAM address at 0; the result is masked by in_map
    always_comb begin
        in_map = de_in && tx < 7'(H_TILES) && ty < 7'(V_TILES);
        addr_a = in_map ? tile_addr(tx, ty) : '0;
        g_in = gx < 7'(H_TILES) && gy < 6'(V_TILES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx1 <= '0;
            sy1 <= '0;
            de1 <= 1'b0;
            in1 <= 1'b0;
            sx <= '0;
            sy <= '0;
            de_out <= 1'b0;
            sprite_code <= CLEAR_CODE;
        end else begin
            sx1 <= px[2:0];
            sy1 <= py[2:0];
            de1 <= de_in;
            in1 <= in_map;
            sx <= sx1;
            sy <= sy1;
            de_out <= de1;
            sprite_code <= in1 ? q_a : CLEAR_CODE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_n;
            clr_cnt <= clr_cnt_n;
        end
    end

    always_comb begin
        last = clr_cnt == tile_addr_t'(N_TILES - 1);
        state_n = state == IDLE ? (clr_start ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
        clr_cnt_n = state == CLEAR ? clr_cnt + 13'd1 : '0;
    end

    // the clear engine owns port B while busy
    always_comb begin
        clr_busy = state == CLEAR;
        we_b = clr_busy || (wr_en && g_in);
        addr_b = clr_busy ? clr_cnt : (g_in ? tile_addr(gx, {1'b0, gy}) : '0);
        d_b = clr_busy ? CLEAR_CODE : wr_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_oor <= 1'b0;
        end else begin
            rd_valid <= rd_en && state == IDLE;
            rd_oor <= !g_in;
        end
    end

    assign rd_code = rd_valid ? (rd_oor ? CLEAR_CODE : q_b) : '0;

    tile_ram_dp u_ram (
        .clk    (clk),
        .addr_a (addr_a),
        .q_a    (q_a),
        .addr_b (addr_b),
        .we_b   (we_b),
        .d_b    (d_b),
        .q_b    (q_b)
    );
endmodule

// File: tb/tb_tile_fetcher.sv
// tb_tile_fetcher: directed and random checks of tile_fetcher against a flat tile-array model
module tb_tile_fetcher;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [9:0] px = '0, py = '0;
    logic de_in = 1'b0;
    logic [2:0] sx, sy;
    logic [3:0] sprite_code;
    logic de_out;
    logic [6:0] gx = '0;
    logic [5:0] gy = '0;
    logic wr_en = 1'b0, rd_en = 1'b0, clr_start = 1'b0;
    logic [3:0] wr_code = '0;
    logic [3:0] rd_code;
    logic rd_valid, clr_busy;

    int total = 0;
    int bad = 0;
    logic [3:0] model [4800];
    logic [3:0] prev_code;
    logic [2:0] prev_sx, prev_sy;
    logic prev_de, prev_v;

    always #5 clk = ~clk;

    tile_fetcher dut (
        .clk(clk), .rst_n(rst_n), .px(px), .py(py), .de_in(de_in),
        .sx(sx), .sy(sy), .sprite_code(sprite_code), .de_out(de_out),
        .gx(gx), .gy(gy), .wr_en(wr_en), .wr_code(wr_code), .rd_en(rd_en),
        .rd_code(rd_code), .rd_valid(rd_valid), .clr_start(clr_start), .clr_busy(clr_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_tile(input int x, input int y);
        return (x < 80 && y < 60) ? model[y * 80 + x] : 4'h8;
    endfunction

    function automatic logic [3:0] ref_disp(input int xp, input int yp, input logic de);
        return de ? ref_tile(xp / 8, yp / 8) : 4'h8;
    endfunction

    task automatic fill_model(input logic [3:0] c);
        for (int i = 0; i < 4800; i++) model[i] = c;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_sx"}, 32'(sx), 0);
        chk({tag, "_sy"}, 32'(sy), 0);
        chk({tag, "_de_out"}, 32'(de_out), 0);
        chk({tag, "_code"}, 32'(sprite_code), 8);
        chk({tag, "_rd_code"}, 32'(rd_code), 0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
        chk({tag, "_busy"}, 32'(clr_busy), 1);
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (clr_busy && n < 6000);
        chk(tag, n, 4800);
    endtask

    task automatic game_read(input int x, input int y);
        gx = 7'(x);
        gy = 6'(y);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("rd_valid", 32'(rd_valid), 1);
        chk("rd_code", 32'(rd_code), 32'(ref_tile(x, y)));
    endtask

    task automatic game_write(input int x, input int y, input logic [3:0] c);
        gx = 7'(x);
        gy = 6'(y);
        wr_code = c;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        if (x < 80 && y < 60) model[y * 80 + x] = c;
    endtask

    task automatic read_all();
        for (int y = 0; y < 60; y++)
            for (int x = 0; x < 80; x++) game_read(x, y);
    endtask

    // display result for one drive appears after the following drive's clock edge
    task automatic disp(input int xp, input int yp, input logic de,
                        input logic we, input int wx, input int wy, input logic [3:0] wc);
        logic [3:0] e;
        e = ref_disp(xp, yp, de);
        px = 10'(xp);
        py = 10'(yp);
        de_in = de;
        wr_en = we;
        gx = 7'(wx);
        gy = 6'(wy);
        wr_code = wc;
        step();
        wr_en = 1'b0;
        if (we && wx < 80 && wy < 60) model[wy * 80 + wx] = wc;
        if (prev_v) begin
            chk("disp_code", 32'(sprite_code), 32'(prev_code));
            chk("disp_sx", 32'(sx), 32'(prev_sx));
            chk("disp_sy", 32'(sy), 32'(prev_sy));
            chk("disp_de", 32'(de_out), 32'(prev_de));
        end
        prev_code = e;
        prev_sx = 3'(xp % 8);
        prev_sy = 3'(yp % 8);
        prev_de = de;
        prev_v = 1'b1;
    endtask

    initial begin
        prev_v = 1'b0;
        #12;
        reset_vals("rst");
        step();
        rst_n = 1'b1;
        count_busy("busy_after_reset");
        fill_model(4'h8);
        read_all();

        game_write(5, 2, 4'h9);
        prev_v = 1'b0;
        for (int y = 8; y < 32; y++)
            for (int x = 32; x < 56; x++) disp(x, y, 1'b1, 1'b0, 0, 0, 4'h0);
        disp(40, 16, 1'b1, 1'b1, 5, 2, 4'hC);
        disp(40, 16, 1'b1, 1'b0, 0, 0, 4'h0);
        disp(0, 0, 1'b0, 1'b0, 0, 0, 4'h0);

        gx = 7'd3;
        gy = 6'd3;
        wr_code = 4'hA;
        wr_en = 1'b1;
        rd_en = 1'b1;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("same_cycle_valid", 32'(rd_valid), 1);
        chk("same_cycle_old", 32'(rd_code), 8);
        model[3 * 80 + 3] = 4'hA;
        step();
        chk("valid_pulse", 32'(rd_valid), 0);
        game_read(3, 3);

        prev_v = 1'b0;
        disp(700, 100, 1'b1, 1'b0, 0, 0, 4'h0);
        disp(40, 16, 1'b0, 1'b0, 0, 0, 4'h0);
        disp(44, 500, 1'b1, 1'b0, 0, 0, 4'h0);
        disp(24, 24, 1'b1, 1'b0, 0, 0, 4'h0);
        disp(0, 0, 1'b0, 1'b0, 0, 0, 4'h0);
        game_write(90, 3, 4'h5);
        game_write(3, 60, 4'h5);
        game_read(90, 3);
        game_read(3, 60);

        prev_v = 1'b0;
        for (int i = 0; i < 400; i++)
            disp(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 1'($urandom),
                 1'($urandom), int'($urandom_range(0, 85)), int'($urandom_range(0, 63)), 4'($urandom));
        disp(0, 0, 1'b0, 1'b0, 0, 0, 4'h0);
        for (int i = 0; i < 200; i++)
            game_read(int'($urandom_range(0, 85)), int'($urandom_range(0, 63)));
        read_all();

        for (int y = 0; y < 60; y++)
            for (int x = 0; x < 80; x++) game_write(x, y, 4'h1);
        game_read(79, 59);
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        chk("clr_busy_rise", 32'(clr_busy), 1);
        begin
            int n = 0;
            while (clr_busy && n < 6000) begin
                n++;
                gx = 7'd1;
                gy = 6'd1;
                wr_code = 4'h3;
                wr_en = 1'b1;
                rd_en = 1'b1;
                step();
                chk("busy_no_rd_valid", 32'(rd_valid), 0);
            end
            wr_en = 1'b0;
            rd_en = 1'b0;
            chk("clear_cycles", n, 4800);
        end
        fill_model(4'h8);
        read_all();

        px = 10'd45;
        py = 10'd19;
        de_in = 1'b1;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (2000) step();
        chk("pre_reset_sx", 32'(sx), 5);
        #2;
        rst_n = 1'b0;
        #1;
        reset_vals("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_busy("busy_after_mid_reset");
        game_read(5, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
